// File: rtl/fft_reorder_pkg.sv
// Shared types and helpers for the bit-reversed to natural-order FFT output buffer.
package fft_reorder_pkg;

    localparam int unsigned LANES    = 4;
    localparam int unsigned FFT_SFPW = 16;

    typedef enum logic {
        WR_IDLE,
        WR_BUSY
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_BUSY
    } rd_state_e;

    function automatic int unsigned bitrev(input int unsigned value, input int unsigned width);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < width; i++) begin
            r = r | (((value >> i) & 32'd1) << (width - 1 - i));
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One skewed storage bank: simple dual-port RAM with a registered read port.
module fft_reorder_bank #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned W     = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong 4-bank reorder buffer: bit-reversed frames in, natural-order bins out.
// Optional `FFT_REORDER_BYPASS_EN adds a per-frame bypass input (no reordering).
module fft_reorder
    import fft_reorder_pkg::*;
#(
    parameter int unsigned NPOINT = 64,
    parameter int unsigned nb     = FFT_SFPW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
`ifdef FFT_REORDER_BYPASS_EN
    input  logic                  bypass,
`endif
    input  logic [LANES*nb-1:0]   input_data,
    output logic [LANES*nb-1:0]   output_data,
    output logic                  out_valid,
    output logic                  out_start,
    output logic                  done
);

    localparam int unsigned M     = $clog2(NPOINT);
    localparam int unsigned BEATS = NPOINT / 4;
    localparam int unsigned KW    = M - 2;
    localparam int unsigned AW    = M - 1;
    localparam int unsigned DEPTH = 2 * BEATS;

    wr_state_e wr_state_q, wr_state_d;
    logic [KW-1:0] wr_cnt_q, wr_cnt_d;
    logic wh_q, wh_d;
    logic [1:0] full_q, full_d;

    rd_state_e rd_state_q, rd_state_d;
    logic [KW-1:0] rd_cnt_q, rd_cnt_d;
    logic rh_q, rh_d;

    logic val_p_q, val_p_d;
    logic first_p_q, first_p_d;
    logic last_p_q, last_p_d;
    logic [LANES-1:0][1:0] lane_bank_q, lane_bank_d;

    logic [LANES-1:0][nb-1:0] output_data_q, output_data_d;
    logic out_valid_q, out_valid_d;
    logic out_start_q, out_start_d;
    logic done_q, done_d;

    logic wr_en;
    logic wr_last;
    logic [KW-1:0] wr_k;
    logic rd_issue;
    logic rd_last;
    logic [KW-1:0] rd_j;
    logic rd_bypass;

    logic [LANES-1:0][nb-1:0] in_lanes;
    logic [LANES-1:0][1:0]    wr_bank;
    logic [LANES-1:0][1:0]    rd_bank;
    logic [LANES-1:0][M-1:0]  rd_n;
    logic [LANES-1:0][AW-1:0] rd_lane_addr;
    logic [LANES-1:0][AW-1:0] bank_raddr;
    logic [LANES-1:0][nb-1:0] bank_wdata;
    logic [LANES-1:0][nb-1:0] bank_rdata;
    logic [AW-1:0]            bank_waddr;

    assign in_lanes = input_data;

`ifdef FFT_REORDER_BYPASS_EN
    logic [1:0] byp_q, byp_d;

    always_comb begin
        byp_d = byp_q;
        if (start) begin
            byp_d[wh_q] = bypass;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byp_q <= '0;
        end else begin
            byp_q <= byp_d;
        end
    end

    assign rd_bypass = byp_q[rh_q];
`else
    assign rd_bypass = 1'b0;
`endif

    // A start always restarts at beat 0 of the current half; an unfinished half never becomes full.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wh_d       = wh_q;
        wr_en      = 1'b0;
        wr_k       = wr_cnt_q;
        if (start) begin
            wr_en = 1'b1;
            wr_k  = '0;
        end else if (wr_state_q == WR_BUSY) begin
            wr_en = 1'b1;
        end
        wr_last = wr_en && (wr_k == KW'(BEATS - 1));
        if (wr_en) begin
            if (wr_last) begin
                wr_state_d = WR_IDLE;
                wr_cnt_d   = '0;
                wh_d       = ~wh_q;
            end else begin
                wr_state_d = WR_BUSY;
                wr_cnt_d   = wr_k + KW'(1);
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rh_d       = rh_q;
        full_d     = full_q;
        rd_issue   = (rd_state_q == RD_BUSY) || full_q[rh_q];
        rd_j       = (rd_state_q == RD_BUSY) ? rd_cnt_q : '0;
        rd_last    = rd_issue && (rd_j == KW'(BEATS - 1));
        if (wr_last) begin
            full_d[wh_q] = 1'b1;
        end
        if (rd_issue) begin
            if (rd_last) begin
                full_d[rh_q] = 1'b0;
                rh_d         = ~rh_q;
                rd_state_d   = RD_IDLE;
                rd_cnt_d     = '0;
            end else begin
                rd_state_d = RD_BUSY;
                rd_cnt_d   = rd_j + KW'(1);
            end
        end
    end

    // Bank skew: bank = (n[M-1:M-2] + n[1:0]) mod 4 keeps all four lanes on distinct banks.
    always_comb begin
        wr_bank      = '0;
        rd_bank      = '0;
        rd_n         = '0;
        rd_lane_addr = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            wr_bank[l] = wr_k[KW-1:KW-2] + 2'(l);
            if (rd_bypass) begin
                rd_n[l] = {rd_j, 2'(l)};
            end else begin
                rd_n[l] = M'(bitrev(32'({rd_j, 2'(l)}), M));
            end
            rd_bank[l]      = rd_n[l][M-1:M-2] + rd_n[l][1:0];
            rd_lane_addr[l] = {rh_q, rd_n[l][M-1:2]};
        end
    end

    always_comb begin
        bank_waddr = {wh_q, wr_k};
        bank_wdata = '0;
        bank_raddr = '0;
        for (int unsigned b = 0; b < LANES; b++) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (wr_bank[l] == 2'(b)) begin
                    bank_wdata[b] = in_lanes[l];
                end
                if (rd_bank[l] == 2'(b)) begin
                    bank_raddr[b] = rd_lane_addr[l];
                end
            end
        end
    end

    for (genvar b = 0; b < LANES; b++) begin : g_bank
        fft_reorder_bank #(
            .DEPTH(DEPTH),
            .W    (nb),
            .AW   (AW)
        ) u_bank (
            .clk  (clk),
            .we   (wr_en),
            .waddr(bank_waddr),
            .wdata(bank_wdata[b]),
            .raddr(bank_raddr[b]),
            .rdata(bank_rdata[b])
        );
    end

    always_comb begin
        val_p_d       = rd_issue;
        first_p_d     = rd_issue && (rd_j == '0);
        last_p_d      = rd_last;
        lane_bank_d   = rd_bank;
        out_valid_d   = val_p_q;
        out_start_d   = first_p_q;
        done_d        = last_p_q;
        output_data_d = output_data_q;
        if (val_p_q) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                output_data_d[l] = bank_rdata[lane_bank_q[l]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q    <= WR_IDLE;
            wr_cnt_q      <= '0;
            wh_q          <= 1'b0;
            full_q        <= '0;
            rd_state_q    <= RD_IDLE;
            rd_cnt_q      <= '0;
            rh_q          <= 1'b0;
            val_p_q       <= 1'b0;
            first_p_q     <= 1'b0;
            last_p_q      <= 1'b0;
            lane_bank_q   <= '0;
            output_data_q <= '0;
            out_valid_q   <= 1'b0;
            out_start_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            wr_state_q    <= wr_state_d;
            wr_cnt_q      <= wr_cnt_d;
            wh_q          <= wh_d;
            full_q        <= full_d;
            rd_state_q    <= rd_state_d;
            rd_cnt_q      <= rd_cnt_d;
            rh_q          <= rh_d;
            val_p_q       <= val_p_d;
            first_p_q     <= first_p_d;
            last_p_q      <= last_p_d;
            lane_bank_q   <= lane_bank_d;
            output_data_q <= output_data_d;
            out_valid_q   <= out_valid_d;
            out_start_q   <= out_start_d;
            done_q        <= done_d;
        end
    end

    assign output_data = output_data_q;
    assign out_valid   = out_valid_q;
    assign out_start   = out_start_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fft_reorder.sv
// Scoreboard bench for fft_reorder at NPOINT=16: driver queues expected beats, monitor checks them.
module tb_fft_reorder;

    localparam int unsigned NB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [4*NB-1:0] input_data;
    logic [4*NB-1:0] output_data;
    logic          out_valid;
    logic          out_start;
    logic          done;
`ifdef FFT_REORDER_BYPASS_EN
    logic          bypass;
`endif

    fft_reorder #(
        .NPOINT(16),
        .nb    (NB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
`ifdef FFT_REORDER_BYPASS_EN
        .bypass     (bypass),
`endif
        .input_data (input_data),
        .output_data(output_data),
        .out_valid  (out_valid),
        .out_start  (out_start),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*NB-1:0] data;
        bit              st;
        bit              dn;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    bit   mon_en      = 1'b0;

    // Bit-reversal of 0..15 over 4 bits, written out by hand.
    int br4 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got %h expected no output (cycle %0d)", output_data, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("beat_data", 64'(output_data), 64'(e.data));
                    check("beat_out_start", 64'(out_start), 64'(e.st));
                    check("beat_done", 64'(done), 64'(e.dn));
                    check("beat_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (out_start !== 1'b0 || done !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL stray_flag: got start=%b done=%b expected 0 0 (cycle %0d)", out_start, done, cyc);
            end
        end
    end

    // Drives nbeats beats from start; queues the first npush expected output beats of a complete frame.
    task automatic drive_frame(input int off, input int nbeats, input bit byp, input int npush);
        int last_cyc;
        last_cyc = 0;
        for (int k = 0; k < nbeats; k++) begin
            start = (k == 0);
`ifdef FFT_REORDER_BYPASS_EN
            bypass = byp;
`endif
            for (int l = 0; l < 4; l++) begin
                input_data[l*NB +: NB] = NB'(byp ? (4*k + l + off) : (br4[4*k + l] + off));
            end
            @(posedge clk);
            #1;
            last_cyc = cyc;
        end
        start      = 1'b0;
        input_data = '0;
        for (int j = 0; j < npush; j++) begin
            exp_t e;
            for (int l = 0; l < 4; l++) begin
                e.data[l*NB +: NB] = NB'(4*j + l + off);
            end
            e.st  = (j == 0);
            e.dn  = (j == 3);
            e.cyc = last_cyc + 2 + j;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int flag_cycles;
        reset      = 1'b1;
        start      = 1'b0;
        input_data = '0;
`ifdef FFT_REORDER_BYPASS_EN
        bypass = 1'b0;
`endif
        idle(3);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_start", 64'(out_start), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_output_data", 64'(output_data), 64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Idle: no start, no activity.
        flag_cycles = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || out_start !== 1'b0 || done !== 1'b0) flag_cycles++;
        end
        #1;
        check("idle_flag_cycles", 64'(flag_cycles), 64'd0);

        // Single frame.
        drive_frame(0, 4, 1'b0, 4);
        idle(8);

        // Back-to-back frames.
        drive_frame(0, 4, 1'b0, 4);
        drive_frame(16, 4, 1'b0, 4);
        idle(10);

        // Aborted frame followed by a full one.
        drive_frame(100, 2, 1'b0, 0);
        drive_frame(32, 4, 1'b0, 4);
        idle(8);

        // Reset while beat 1 is on the output.
        drive_frame(48, 4, 1'b0, 2);
        idle(2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_out_start", 64'(out_start), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_output_data", 64'(output_data), 64'd0);
        idle(10);
        drive_frame(64, 4, 1'b0, 4);
        idle(8);

`ifdef FFT_REORDER_BYPASS_EN
        // Bypass frame, then a reordered frame right behind it.
        drive_frame(0, 4, 1'b1, 4);
        drive_frame(80, 4, 1'b0, 4);
        idle(10);
`endif

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
